// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and opcode classification helpers for alu_seq
// Purpose: shared definitions imported by alu_seq and alu_seq_comb.
// Ports: none (package).
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADDU = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_MULU = 4'b0100;
  localparam logic [3:0] OP_SUBU = 4'b0110;
  localparam logic [3:0] OP_NOT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ADDS = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1101;
  localparam logic [3:0] OP_SUBS = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return op inside {OP_SLL, OP_SRL, OP_SRA};
  endfunction

  // Ops that may use the iterative engine (shifts only do so for a non-zero amount).
  function automatic logic is_multicycle(input logic [3:0] op);
    return is_shift(op) || (op == OP_MULU);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {OP_AND, OP_OR, OP_ADDU, OP_XOR, OP_MULU, OP_SUBU, OP_NOT,
                      OP_SRL, OP_SRA, OP_ADDS, OP_NOR, OP_SLL, OP_SUBS};
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - combinational logic/add/sub datapath for alu_seq
// Purpose: single-cycle result plus carry/overflow for logic and add/sub ops.
// Ports: op (opcode), a, b (operands) -> result, c (carry/borrow), v (overflow).
//        Ops outside this group produce result=0, c=0, v=0.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // diff[WIDTH] is the unsigned borrow (a < b).
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_NOT: result = ~a;
      OP_ADDU: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = sum[WIDTH];
      end
      OP_SUBU: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = diff[WIDTH];
      end
      OP_ADDS: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBS: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative shifts and shift-add unsigned multiply
// Purpose: accepts one op in IDLE, computes it (1 cycle, or via the iterative engine),
//          presents result/flags in DONE until out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, op, a, b (request side);
//        out_valid/out_ready, result, c, z, n, v, illegal (response side).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             illegal
);

  // Counter must hold WIDTH itself for the multiply.
  localparam int CW = SHW + 1;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Shifts use the low half; multiply keeps {partial product, remaining multiplier}.
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d, illegal_q, illegal_d;

  logic [WIDTH-1:0]   comb_result;
  logic               comb_c, comb_v;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_work;
  logic               step_c;
  logic               load, ld_c, ld_v, ld_ill;
  logic [WIDTH-1:0]   ld_result;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .op     (op),
    .a      (a),
    .b      (b),
    .result (comb_result),
    .c      (comb_c),
    .v      (comb_v)
  );

  // One iteration of the engine for the latched op.
  always_comb begin
    addend    = work_q[0] ? mcand_q : '0;
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    step_c    = 1'b0;
    step_work = work_q;
    case (op_q)
      OP_SLL: begin
        step_c    = work_q[WIDTH-1];
        step_work = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-2:0], 1'b0};
      end
      OP_SRL: begin
        step_c    = work_q[0];
        step_work = {work_q[2*WIDTH-1:WIDTH], 1'b0, work_q[WIDTH-1:1]};
      end
      OP_SRA: begin
        step_c    = work_q[0];
        step_work = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1], work_q[WIDTH-1:1]};
      end
      OP_MULU: step_work = {mul_sum, work_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    illegal_d = illegal_q;
    load      = 1'b0;
    ld_result = '0;
    ld_c      = 1'b0;
    ld_v      = 1'b0;
    ld_ill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          mcand_d = a;
          if (is_multicycle(op) && ((op == OP_MULU) || (b[SHW-1:0] != '0))) begin
            state_d = BUSY;
            if (op == OP_MULU) begin
              work_d = {{WIDTH{1'b0}}, b};
              cnt_d  = CW'(WIDTH);
            end else begin
              work_d = {{WIDTH{1'b0}}, a};
              cnt_d  = CW'(b[SHW-1:0]);
            end
          end else begin
            state_d = DONE;
            load    = 1'b1;
            if (!is_legal(op)) begin
              ld_ill = 1'b1;
            end else if (is_shift(op)) begin
              ld_result = a;  // zero-amount shift passes a through with c=0
            end else begin
              ld_result = comb_result;
              ld_c      = comb_c;
              ld_v      = comb_v;
            end
          end
        end
      end
      BUSY: begin
        work_d = step_work;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          load      = 1'b1;
          ld_result = step_work[WIDTH-1:0];
          if (op_q == OP_MULU) begin
            ld_c = |step_work[2*WIDTH-1:WIDTH];
            ld_v = |step_work[2*WIDTH-1:WIDTH];
          end else begin
            ld_c = step_c;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      result_d  = ld_result;
      c_d       = ld_c;
      v_d       = ld_v;
      z_d       = (ld_result == '0);
      n_d       = ld_result[WIDTH-1];
      illegal_d = ld_ill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      mcand_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      c_q       <= c_d;
      z_q       <= z_d;
      n_q       <= n_d;
      v_q       <= v_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign c         = c_q;
  assign z         = z_q;
  assign n         = n_q;
  assign v         = v_q;
  assign illegal   = illegal_q;

endmodule
